pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the four-stage fetch/decode/execute/memory vector core. It watches the decode, execute and memory stages. It generates PC-enable, IF/ID-enable and per-stage flush controls so that:
- load-use hazards stall the front end;
- taken jumps resolved in memory squash younger instructions;
- a memory-stage `flagEnd` halts the core until reset.

It sits beside the pipeline registers and drives their enable and flush inputs and the PC-select mux.

---
 rtl/pipe_ctrl_pkg.sv | 46 ++++
 rtl/hazard_cmp.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// performance counter width and the bundled pipeline control word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    localparam int PERF_CNT_W = 16;

    typedef struct packed {
        logic pcEn;
        logic pcSelJump;
        logic ifidEn;
        logic ifidFlush;
        logic idexFlush;
        logic exmemFlush;
    } ctrl_out_t;

    // Normal flow: everything advances, no bubbles.
    function automatic ctrl_out_t ctrlRun();
        return '{pcEn: 1'b1, pcSelJump: 1'b0, ifidEn: 1'b1,
                 ifidFlush: 1'b0, idexFlush: 1'b0, exmemFlush: 1'b0};
    endfunction

    // Load-use bubble: freeze the front end and inject a bubble into ID/EX.
    function automatic ctrl_out_t ctrlStall();
        return '{pcEn: 1'b0, pcSelJump: 1'b0, ifidEn: 1'b0,
                 ifidFlush: 1'b0, idexFlush: 1'b1, exmemFlush: 1'b0};
    endfunction

    // Taken jump: squash all younger work and redirect the PC.
    function automatic ctrl_out_t ctrlJump();
        return '{pcEn: 1'b1, pcSelJump: 1'b1, ifidEn: 1'b1,
                 ifidFlush: 1'b1, idexFlush: 1'b1, exmemFlush: 1'b1};
    endfunction

    // End / halt / reset: nothing advances and every pipe register is a bubble.
    function automatic ctrl_out_t ctrlFreeze();
        return '{pcEn: 1'b0, pcSelJump: 1'b0, ifidEn: 1'b0,
                 ifidFlush: 1'b1, idexFlush: 1'b1, exmemFlush: 1'b1};
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard comparator: flags a decode-stage instruction that reads a
// register the execute-stage load has not yet produced.
module hazard_cmp #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2
) (
    input  logic                 decNop,
    input  logic [REGI_BITS-1:0] decSrc1,
    input  logic [REGI_BITS-1:0] decSrc2,
    input  logic                 decSrc1Int,
    input  logic                 decSrc2Int,
    input  logic [VECT_BITS-1:0] decVsrc1,
    input  logic [VECT_BITS-1:0] decVsrc2,
    input  logic                 decSrc1V,
    input  logic                 decSrc2V,
    input  logic                 exeMemRead,
    input  logic                 exeWrInt,
    input  logic                 exeWrV,
    input  logic [REGI_BITS-1:0] exeIntDest,
    input  logic [VECT_BITS-1:0] exeVecDest,
    output logic                 haz
);

    logic intHit;
    logic vecHit;

    // Match used sources against the load destination of the matching register file.
    always_comb begin
        intHit = exeWrInt && ((decSrc1Int && (decSrc1 == exeIntDest)) ||
                              (decSrc2Int && (decSrc2 == exeIntDest)));
        vecHit = exeWrV && ((decSrc1V && (decVsrc1 == exeVecDest)) ||
                            (decSrc2V && (decVsrc2 == exeVecDest)));
        haz    = !decNop && exeMemRead && (intHit || vecHit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls on load-use hazards, squashes on
// memory-stage jumps and halts on the end flag until reset.
// Optional macro HAZ_PERF_CNT_EN builds saturating stall/flush counters;
// without it the counter ports read 0.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGI_BITS    = 4,
    parameter int VECT_BITS    = 2,
    parameter int STALL_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dec_nop_i,
    input  logic [REGI_BITS-1:0]  dec_src1_i,
    input  logic [REGI_BITS-1:0]  dec_src2_i,
    input  logic                  dec_src1_int_i,
    input  logic                  dec_src2_int_i,
    input  logic [VECT_BITS-1:0]  dec_vsrc1_i,
    input  logic [VECT_BITS-1:0]  dec_vsrc2_i,
    input  logic                  dec_src1_v_i,
    input  logic                  dec_src2_v_i,
    input  logic                  exe_mem_read_i,
    input  logic                  exe_wr_int_i,
    input  logic                  exe_wr_v_i,
    input  logic [REGI_BITS-1:0]  exe_int_dest_i,
    input  logic [VECT_BITS-1:0]  exe_vec_dest_i,
    input  logic                  mem_jump_i,
    input  logic                  mem_end_i,
    output logic                  pc_en_o,
    output logic                  pc_sel_jump_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  exmem_flush_o,
    output logic                  halted_o,
    output logic [1:0]            state_o,
    output logic [PERF_CNT_W-1:0] stall_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o
);

    localparam int SW = $clog2(STALL_CYCLES + 1);

    ctrl_state_t state, stateNext;
    logic [SW-1:0] scnt, scntNext;
    ctrl_out_t ctrl, ctrlOut;
    logic haz;
    logic stallEvent;
    logic jumpEvent;

    hazard_cmp #(
        .REGI_BITS(REGI_BITS),
        .VECT_BITS(VECT_BITS)
    ) hazardCmp (
        .decNop    (dec_nop_i),
        .decSrc1   (dec_src1_i),
        .decSrc2   (dec_src2_i),
        .decSrc1Int(dec_src1_int_i),
        .decSrc2Int(dec_src2_int_i),
        .decVsrc1  (dec_vsrc1_i),
        .decVsrc2  (dec_vsrc2_i),
        .decSrc1V  (dec_src1_v_i),
        .decSrc2V  (dec_src2_v_i),
        .exeMemRead(exe_mem_read_i),
        .exeWrInt  (exe_wr_int_i),
        .exeWrV    (exe_wr_v_i),
        .exeIntDest(exe_int_dest_i),
        .exeVecDest(exe_vec_dest_i),
        .haz       (haz)
    );

    // Next-state and same-cycle control decode; end beats jump beats hazard.
    always_comb begin
        ctrl       = ctrlRun();
        stateNext  = state;
        scntNext   = scnt;
        stallEvent = 1'b0;
        jumpEvent  = 1'b0;
        case (state)
            RUN: begin
                if (mem_end_i) begin
                    ctrl      = ctrlFreeze();
                    stateNext = HALT;
                end else if (mem_jump_i) begin
                    ctrl      = ctrlJump();
                    jumpEvent = 1'b1;
                end else if (haz) begin
                    ctrl       = ctrlStall();
                    stallEvent = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        scntNext  = SW'(STALL_CYCLES - 1);
                        stateNext = STALL;
                    end
                end
            end
            STALL: begin
                if (mem_end_i) begin
                    ctrl      = ctrlFreeze();
                    stateNext = HALT;
                    scntNext  = '0;
                end else if (mem_jump_i) begin
                    ctrl      = ctrlJump();
                    jumpEvent = 1'b1;
                    stateNext = RUN;
                    scntNext  = '0;
                end else begin
                    ctrl       = ctrlStall();
                    stallEvent = 1'b1;
                    scntNext   = scnt - SW'(1);
                    if (scnt == SW'(1)) begin
                        stateNext = RUN;
                    end
                end
            end
            HALT: begin
                ctrl = ctrlFreeze();
            end
            default: begin
                ctrl      = ctrlFreeze();
                stateNext = RUN;
                scntNext  = '0;
            end
        endcase
    end

    // FSM state and stall-remaining counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            scnt  <= '0;
        end else begin
            state <= stateNext;
            scnt  <= scntNext;
        end
    end

    // Reset overrides the decoded controls so the pipe is held bubbled.
    always_comb begin
        ctrlOut = rst_i ? ctrlFreeze() : ctrl;
    end

    assign pc_en_o       = ctrlOut.pcEn;
    assign pc_sel_jump_o = ctrlOut.pcSelJump;
    assign ifid_en_o     = ctrlOut.ifidEn;
    assign ifid_flush_o  = ctrlOut.ifidFlush;
    assign idex_flush_o  = ctrlOut.idexFlush;
    assign exmem_flush_o = ctrlOut.exmemFlush;
    assign halted_o      = !rst_i && (state == HALT);
    assign state_o       = state;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stallCnt;
    logic [PERF_CNT_W-1:0] flushCnt;

    // Saturating counts of hazard bubbles and jump flushes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallEvent && (stallCnt != {PERF_CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (jumpEvent && (flushCnt != {PERF_CNT_W{1'b1}})) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stallCnt;
    assign flush_cnt_o = flushCnt;
`else
    logic unusedEvents;
    assign unusedEvents = stallEvent ^ jumpEvent;
    assign stall_cnt_o  = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule
